// File: rtl/qpmm_pkg.sv
// Shared BN254 Fp constants and types for the streaming Montgomery front-end.
// R is 2**FP_W; R2 and the Montgomery inverse are derived from Mod at elaboration.
package qpmm_pkg;

    localparam int FP_W = 272;

    typedef logic [FP_W-1:0] qpmm_fp_t;

    localparam qpmm_fp_t Mod = FP_W'(
        256'h30644e72e131a029b85045b68181585d97816a916871ca8d3c208c16d87cfd47);

    typedef enum logic [1:0] {
        MODE_MUL       = 2'b00,
        MODE_SQR       = 2'b01,
        MODE_TO_MONT   = 2'b10,
        MODE_FROM_MONT = 2'b11
    } qpmm_mode_t;

    // R^2 mod p by repeated modular doubling of 1.
    function automatic qpmm_fp_t calc_r2();
        logic [FP_W:0] x;
        x = '0;
        x[0] = 1'b1;
        for (int i = 0; i < 2 * FP_W; i++) begin
            x = x << 1;
            if (x >= {1'b0, Mod}) x = x - {1'b0, Mod};
        end
        return x[FP_W-1:0];
    endfunction

    // -p^-1 mod R via Newton iteration; each step doubles the correct bits.
    function automatic qpmm_fp_t calc_minv();
        qpmm_fp_t inv;
        inv = FP_W'(1);
        for (int i = 0; i < 9; i++) begin
            inv = inv * (FP_W'(2) - Mod * inv);
        end
        return FP_W'(0) - inv;
    endfunction

    localparam qpmm_fp_t R2   = calc_r2();
    localparam qpmm_fp_t ONE  = FP_W'(1);
    localparam qpmm_fp_t MInv = calc_minv();

endpackage

// File: rtl/QPMM_d0_16_16.sv
// Fixed-latency Montgomery multiplier core: z = a*b*R^-1 mod p.
// Free running, no stall and no data reset; result emerges LATENCY edges later.
module QPMM_d0_16_16
    import qpmm_pkg::*;
#(
    parameter int LATENCY = 22
) (
    input  logic     clk,
    input  qpmm_fp_t a,
    input  qpmm_fp_t b,
    output qpmm_fp_t z
);

    localparam int DW = 2 * FP_W;

    logic [DW-1:0] t;
    logic [DW-1:0] mp;
    logic [DW:0]   u;
    qpmm_fp_t      m;
    logic [FP_W:0] s;
    logic [FP_W:0] d;
    qpmm_fp_t      zc;
    logic          unused_lo;

    always_comb begin
        t  = {{FP_W{1'b0}}, a} * {{FP_W{1'b0}}, b};
        m  = t[FP_W-1:0] * MInv;
        mp = {{FP_W{1'b0}}, m} * {{FP_W{1'b0}}, Mod};
        u  = {1'b0, t} + {1'b0, mp};
        s  = u[DW:FP_W];
        d  = s - {1'b0, Mod};
        zc = (s >= {1'b0, Mod}) ? d[FP_W-1:0] : s[FP_W-1:0];
    end

    // Low half of t + m*p is zero by construction.
    assign unused_lo = ^{u[FP_W-1:0], d[FP_W]};

    qpmm_fp_t pipe [LATENCY];

    always_ff @(posedge clk) begin
        pipe[0] <= zc;
        for (int i = 1; i < LATENCY; i++) begin
            pipe[i] <= pipe[i-1];
        end
    end

    assign z = pipe[LATENCY-1];

endmodule

// File: rtl/qpmm_out_fifo.sv
// Show-ahead result FIFO with registered pointers and count.
// Pointers wrap modulo DEPTH, so DEPTH need not be a power of two.
module qpmm_out_fifo #(
    parameter int W     = 280,
    parameter int DEPTH = 32
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_en,
    output logic [W-1:0] rd_data,
    output logic         empty,
    output logic         full
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [CW-1:0] count;
    logic          do_rd;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));
    assign do_rd = rd_en && !empty;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (wr_en) wptr <= nxt(wptr);
            if (do_rd) rptr <= nxt(rptr);
            count <= count + CW'(wr_en) - CW'(do_rd);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wptr] <= wr_data;
    end

    assign rd_data = empty ? '0 : mem[rptr];

    a_no_overflow : assert property (
        @(posedge clk) disable iff (!rstn) !(wr_en && full && !rd_en));

endmodule

// File: rtl/qpmm_stream.sv
// Valid/ready front-end for the Montgomery core with tag shadow pipe and
// credit-based output buffering so the core never stalls.
module qpmm_stream
    import qpmm_pkg::*;
#(
    parameter int WIDTH   = 272,
    parameter int LATENCY = 22,
    parameter int DEPTH   = 32,
    parameter int TAG_W   = 8
) (
    input  logic                       clk,
    input  logic                       rstn,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [1:0]                 in_mode,
    input  logic [WIDTH-1:0]           in_a,
    input  logic [WIDTH-1:0]           in_b,
    input  logic [TAG_W-1:0]           in_tag,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [TAG_W-1:0]           out_tag,
    output logic [$clog2(DEPTH+1)-1:0] inflight
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [CW-1:0]          cred;
    logic                   acc;
    logic                   pop;
    logic                   empty;
    logic                   full;
    qpmm_fp_t               core_a;
    qpmm_fp_t               core_b;
    qpmm_fp_t               core_z;
    logic [LATENCY-1:0]     sv;
    logic [TAG_W-1:0]       stag [LATENCY];
    logic [WIDTH+TAG_W-1:0] head;

    assign in_ready  = (cred != '0);
    assign acc       = in_valid && in_ready;
    assign out_valid = !empty;
    assign pop       = out_valid && out_ready;
    assign inflight  = CW'(DEPTH) - cred;

    // Bubbles feed zeros so the core sees no stale operands.
    always_comb begin
        core_a = '0;
        core_b = '0;
        if (acc) begin
            core_a = in_a;
            unique case (qpmm_mode_t'(in_mode))
                MODE_MUL:       core_b = in_b;
                MODE_SQR:       core_b = in_a;
                MODE_TO_MONT:   core_b = R2;
                MODE_FROM_MONT: core_b = ONE;
            endcase
        end
    end

    QPMM_d0_16_16 #(
        .LATENCY(LATENCY)
    ) u_core (
        .clk(clk),
        .a  (core_a),
        .b  (core_b),
        .z  (core_z)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sv   <= '0;
            cred <= CW'(DEPTH);
        end else begin
            sv <= LATENCY'({sv, acc});
            case ({acc, pop})
                2'b10:   cred <= cred - 1'b1;
                2'b01:   cred <= cred + 1'b1;
                default: cred <= cred;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        stag[0] <= in_tag;
        for (int i = 1; i < LATENCY; i++) begin
            stag[i] <= stag[i-1];
        end
    end

    qpmm_out_fifo #(
        .W    (WIDTH + TAG_W),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rstn   (rstn),
        .wr_en  (sv[LATENCY-1]),
        .wr_data({core_z, stag[LATENCY-1]}),
        .rd_en  (pop),
        .rd_data(head),
        .empty  (empty),
        .full   (full)
    );

    assign {out_data, out_tag} = head;

endmodule

// File: tb/tb_qpmm_stream.sv
// Randomised bench for qpmm_stream against a modular-arithmetic reference model.
// A result z is correct when z*R == a*b (mod p) for the mode-selected b.
module tb_qpmm_stream;

    localparam int W  = 272;
    localparam int L  = 22;
    localparam int D  = 32;
    localparam int TW = 8;
    localparam int CW = 6;

    localparam logic [1023:0] P = 1024'h30644e72e131a029b85045b68181585d97816a916871ca8d3c208c16d87cfd47;

    typedef struct {
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic [TW-1:0] tag;
    } op_t;

    logic          clk;
    logic          rstn;
    logic          in_valid;
    logic          in_ready;
    logic [1:0]    in_mode;
    logic [W-1:0]  in_a;
    logic [W-1:0]  in_b;
    logic [TW-1:0] in_tag;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_data;
    logic [TW-1:0] out_tag;
    logic [CW-1:0] inflight;

    op_t           sb[$];
    int            tests = 0;
    int            fails = 0;
    logic [1023:0] rmod;
    logic [1023:0] r2;

    qpmm_stream #(
        .WIDTH(W), .LATENCY(L), .DEPTH(D), .TAG_W(TW)
    ) dut (
        .clk(clk), .rstn(rstn),
        .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_tag(out_tag), .inflight(inflight)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] rand_fp();
        logic [319:0] x;
        for (int i = 0; i < 10; i++) x[i*32 +: 32] = $urandom;
        return W'({704'b0, x} % P);
    endfunction

    function automatic logic [W-1:0] beff(input logic [1:0] m, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
        case (m)
            2'd0:    return b;
            2'd1:    return a;
            2'd2:    return W'(r2);
            default: return W'(1);
        endcase
    endfunction

    function automatic bit good(input op_t e, input logic [W-1:0] z);
        logic [1023:0] lhs;
        logic [1023:0] rhs;
        lhs = ({752'b0, z} << W) % P;
        rhs = ({752'b0, e.a} * {752'b0, e.b}) % P;
        return lhs == rhs;
    endfunction

    // Captures pre-edge handshake state, records accepts, advances one cycle.
    task automatic tick(output logic acc, output logic pop,
                        output logic [W-1:0] d, output logic [TW-1:0] t);
        op_t e;
        acc = in_valid && in_ready;
        pop = out_valid && out_ready;
        d   = out_data;
        t   = out_tag;
        if (acc) begin
            e.a   = in_a;
            e.b   = beff(in_mode, in_a, in_b);
            e.tag = in_tag;
            sb.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rstn = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_mode = 2'd0; in_a = '0; in_b = '0; in_tag = '0;
        repeat (3) @(negedge clk);
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        tests++; if (out_data !== '0) begin fails++; $display("FAIL reset_out_data: got %0h want 0", out_data); end
        tests++; if (out_tag !== '0) begin fails++; $display("FAIL reset_out_tag: got %0h want 0", out_tag); end
        tests++; if (inflight !== '0) begin fails++; $display("FAIL reset_inflight: got %0d want 0", inflight); end
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_modes();
        logic acc, pop; logic [W-1:0] d; logic [TW-1:0] t; op_t e; int n;
        out_ready = 1'b0;
        in_valid = 1'b1; in_mode = 2'd2; in_a = W'(5); in_b = rand_fp(); in_tag = 8'h11;
        tick(acc, pop, d, t);
        in_valid = 1'b0;
        tests++; if (acc !== 1'b1) begin fails++; $display("FAIL to_mont_accept: got %b want 1", acc); end
        repeat (L - 1) tick(acc, pop, d, t);
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL latency_early: out_valid %b want 0", out_valid); end
        repeat (2) tick(acc, pop, d, t);
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL latency: out_valid %b want 1", out_valid); end
        tests++; if (out_tag !== 8'h11) begin fails++; $display("FAIL to_mont_tag: got %0h want 11", out_tag); end
        tests++;
        if (({752'b0, out_data} % P) !== (rmod * 5) % P) begin
            fails++; $display("FAIL to_mont_data: got %0h want 5R mod p", out_data);
        end
        in_valid = 1'b1; in_mode = 2'd3; in_a = W'(rmod); in_tag = 8'h22;
        tick(acc, pop, d, t);
        in_mode = 2'd1; in_a = W'((rmod * 2) % P); in_tag = 8'h33;
        tick(acc, pop, d, t);
        in_valid = 1'b0; out_ready = 1'b1;
        n = 0;
        for (int c = 0; c < L + 8 && n < 3; c++) begin
            if (out_valid && out_tag == 8'h22) begin
                tests++;
                if (({752'b0, out_data} % P) !== 1) begin
                    fails++; $display("FAIL from_mont_data: got %0h want 1 mod p", out_data);
                end
            end
            tick(acc, pop, d, t);
            if (pop) begin
                n++; tests++;
                if (sb.size() == 0) begin
                    fails++; $display("FAIL modes_spurious: tag %0h with nothing outstanding", t);
                end else begin
                    e = sb.pop_front();
                    if (!good(e, d) || t !== e.tag) begin
                        fails++; $display("FAIL modes_result: got tag %0h data %0h want tag %0h", t, d, e.tag);
                    end
                end
            end
        end
        tests++; if (n != 3) begin fails++; $display("FAIL modes_count: got %0d want 3", n); end
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic acc, pop; logic [W-1:0] d; logic [TW-1:0] t; op_t e; int drops;
        drops = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            in_valid = 1'b1; in_mode = 2'd0;
            in_a = rand_fp(); in_b = rand_fp(); in_tag = i[7:0];
            if (in_ready !== 1'b1) drops++;
            tick(acc, pop, d, t);
            if (pop) begin
                tests++;
                if (sb.size() == 0) begin
                    fails++; $display("FAIL b2b_spurious: tag %0h with nothing outstanding", t);
                end else begin
                    e = sb.pop_front();
                    if (!good(e, d) || t !== e.tag) begin
                        fails++; $display("FAIL b2b_result: got tag %0h data %0h want tag %0h", t, d, e.tag);
                    end
                end
            end
        end
        in_valid = 1'b0;
        for (int c = 0; c < L + 5; c++) begin
            tick(acc, pop, d, t);
            if (pop) begin
                tests++;
                if (sb.size() == 0) begin
                    fails++; $display("FAIL b2b_spurious: tag %0h with nothing outstanding", t);
                end else begin
                    e = sb.pop_front();
                    if (!good(e, d) || t !== e.tag) begin
                        fails++; $display("FAIL b2b_result: got tag %0h data %0h want tag %0h", t, d, e.tag);
                    end
                end
            end
        end
        tests++; if (drops != 0) begin fails++; $display("FAIL b2b_in_ready: dropped %0d times want 0", drops); end
        tests++; if (sb.size() != 0) begin fails++; $display("FAIL b2b_drain: %0d left want 0", sb.size()); end
    endtask

    task automatic test_backpressure();
        logic acc, pop; logic [W-1:0] d; logic [TW-1:0] t; op_t e; int accepts; int pops;
        accepts = 0; pops = 0;
        out_ready = 1'b0;
        for (int c = 0; c < 60; c++) begin
            in_valid = 1'b1; in_mode = 2'd0;
            in_a = rand_fp(); in_b = rand_fp(); in_tag = accepts[7:0];
            tick(acc, pop, d, t);
            if (acc) accepts++;
        end
        in_valid = 1'b0;
        tests++; if (accepts != D) begin fails++; $display("FAIL bp_accepts: got %0d want %0d", accepts, D); end
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end
        tests++; if (inflight !== CW'(D)) begin fails++; $display("FAIL bp_inflight: got %0d want %0d", inflight, D); end
        out_ready = 1'b1;
        for (int c = 0; c < D + 10; c++) begin
            tick(acc, pop, d, t);
            if (c == 0) begin
                tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_credit: in_ready %b want 1", in_ready); end
            end
            if (pop) begin
                pops++; tests++;
                if (sb.size() == 0) begin
                    fails++; $display("FAIL bp_spurious: tag %0h with nothing outstanding", t);
                end else begin
                    e = sb.pop_front();
                    if (!good(e, d) || t !== e.tag) begin
                        fails++; $display("FAIL bp_result: got tag %0h data %0h want tag %0h", t, d, e.tag);
                    end
                end
            end
        end
        tests++; if (pops != D) begin fails++; $display("FAIL bp_pops: got %0d want %0d", pops, D); end
    endtask

    task automatic test_random();
        logic acc, pop; logic [W-1:0] d; logic [TW-1:0] t; op_t e; int bad_inflight;
        bad_inflight = 0;
        for (int c = 0; c < 5000; c++) begin
            in_valid = 1'($urandom); out_ready = 1'($urandom);
            in_mode = 2'($urandom); in_a = rand_fp(); in_b = rand_fp(); in_tag = 8'($urandom);
            if (int'(inflight) != sb.size()) bad_inflight++;
            tick(acc, pop, d, t);
            if (pop) begin
                tests++;
                if (sb.size() == 0) begin
                    fails++; $display("FAIL rand_spurious: tag %0h with nothing outstanding", t);
                end else begin
                    e = sb.pop_front();
                    if (!good(e, d) || t !== e.tag) begin
                        fails++; $display("FAIL rand_result: got tag %0h data %0h want tag %0h", t, d, e.tag);
                    end
                end
            end
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 2 * D + L; c++) begin
            tick(acc, pop, d, t);
            if (pop) begin
                tests++;
                if (sb.size() == 0) begin
                    fails++; $display("FAIL rand_spurious: tag %0h with nothing outstanding", t);
                end else begin
                    e = sb.pop_front();
                    if (!good(e, d) || t !== e.tag) begin
                        fails++; $display("FAIL rand_result: got tag %0h data %0h want tag %0h", t, d, e.tag);
                    end
                end
            end
        end
        tests++; if (bad_inflight != 0) begin fails++; $display("FAIL rand_inflight: %0d cycles off want 0", bad_inflight); end
        tests++; if (sb.size() != 0) begin fails++; $display("FAIL rand_drain: %0d left want 0", sb.size()); end
    endtask

    task automatic test_reset_mid();
        logic acc, pop; logic [W-1:0] d; logic [TW-1:0] t; int accepts; int seen;
        accepts = 0; seen = 0;
        out_ready = 1'b0;
        for (int c = 0; c < 10; c++) begin
            in_valid = 1'b1; in_mode = 2'($urandom);
            in_a = rand_fp(); in_b = rand_fp(); in_tag = 8'(c);
            tick(acc, pop, d, t);
            if (acc) accepts++;
        end
        in_valid = 1'b0;
        tests++; if (accepts != 10) begin fails++; $display("FAIL rst_accepts: got %0d want 10", accepts); end
        rstn = 1'b0;
        #1;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
        tests++; if (inflight !== '0) begin fails++; $display("FAIL rst_inflight: got %0d want 0", inflight); end
        sb.delete();
        @(negedge clk);
        rstn = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < L + 5; c++) begin
            if (out_valid) seen++;
            tick(acc, pop, d, t);
        end
        tests++; if (seen != 0) begin fails++; $display("FAIL rst_stale: %0d output cycles want 0", seen); end
    endtask

    initial begin
        logic [1023:0] one;
        one  = 1;
        rmod = (one << W) % P;
        r2   = (rmod * rmod) % P;
        test_reset();
        test_modes();
        test_back_to_back();
        test_backpressure();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
